// File: rtl/seg7_bcd_scan_if.sv
// Count/display bundle between the tick source and the 7-segment driver.
// The master side drives tick/en/clr. The slave side returns count, wrap and display lines.
interface seg7_bcd_scan_if;
  logic        tick;
  logic        en;
  logic        clr;
  logic [15:0] count;
  logic        wrap;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output tick, en, clr, input count, wrap, an, seg, dp);
  modport slave  (input tick, en, clr, output count, wrap, an, seg, dp);
endinterface

// File: rtl/seg7_bcd_scan.sv
// 4-digit BCD tick counter with multiplexed active-low 7-seg scan; count/wrap 1 clk, an/seg 1 clk after idx/count.
// No backpressure: every qualified tick is counted in the cycle it arrives.
module seg7_bcd_scan #(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input logic            clk,
  input logic            rst,
  seg7_bcd_scan_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PSC_LAST = PW'(SCAN_DIV - 1);

  logic [15:0]   count_q;
  logic [15:0]   count_nxt;
  logic          carry_out;
  logic          wrap_q;
  logic [PW-1:0] psc;
  logic [1:0]    idx;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic [3:0]    digit;
  logic          blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Ripple the carry upward: a digit advances only while every lower digit was 9.
  always_comb begin
    count_nxt = count_q;
    carry_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry_out) begin
        if (count_q[i*4 +: 4] == 4'd9) begin
          count_nxt[i*4 +: 4] = 4'd0;
        end else begin
          count_nxt[i*4 +: 4] = count_q[i*4 +: 4] + 4'd1;
          carry_out = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 16'h0000;
      wrap_q  <= 1'b0;
    end else if (bus.clr) begin
      count_q <= 16'h0000;
      wrap_q  <= 1'b0;
    end else if (bus.en && bus.tick) begin
      count_q <= count_nxt;
      wrap_q  <= carry_out;
    end else begin
      wrap_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc <= '0;
      idx <= 2'd0;
    end else if (psc == PSC_LAST) begin
      psc <= '0;
      idx <= idx + 2'd1;
    end else begin
      psc <= psc + PW'(1);
    end
  end

  // A digit is a leading zero when it and everything above it are zero.
  always_comb begin
    digit = count_q[{idx, 2'b00} +: 4];
    blank = BLANK_LZ && (idx != 2'd0) && ((count_q >> {idx, 2'b00}) == 16'h0000);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_q  <= 4'b1110;
      seg_q <= 7'b1000000;
    end else begin
      an_q  <= ~(4'b0001 << idx);
      seg_q <= blank ? 7'b1111111 : decode(digit);
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = 1'b1;
endmodule

// File: tb/tb_seg7_bcd_scan.sv
// Directed bench for seg7_bcd_scan: table-driven count vectors plus scan, rollover and reset sequences.
module tb_seg7_bcd_scan;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  seg7_bcd_scan_if bus ();

  seg7_bcd_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          rep;
    logic        tick;
    logic        en;
    logic        clr;
    logic [15:0] exp_count;
    logic        exp_wrap_seen;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    bus.en   = 1'b1;
    bus.tick = 1'b1;
    repeat (n) step();
    bus.tick = 1'b0;
  endtask

  // Bounded search for a digit slot; an expired bound shows up as an an-mismatch.
  task automatic wait_an(input logic [3:0] target, input string name);
    int n;
    n = 0;
    while (bus.an !== target && n < 20) begin
      step();
      n++;
    end
    chk(name, 32'(bus.an), 32'(target));
  endtask

  initial begin
    logic wrap_seen;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus.tick = 1'b0;
    bus.en   = 1'b0;
    bus.clr  = 1'b0;

    vecs[0] = '{9,    1'b1, 1'b1, 1'b0, 16'h0009, 1'b0};
    vecs[1] = '{1,    1'b1, 1'b1, 1'b0, 16'h0010, 1'b0};
    vecs[2] = '{89,   1'b1, 1'b1, 1'b0, 16'h0099, 1'b0};
    vecs[3] = '{1,    1'b1, 1'b1, 1'b0, 16'h0100, 1'b0};
    vecs[4] = '{3,    1'b1, 1'b0, 1'b0, 16'h0100, 1'b0};
    vecs[5] = '{42,   1'b1, 1'b1, 1'b1, 16'h0000, 1'b0};
    vecs[6] = '{42,   1'b1, 1'b1, 1'b0, 16'h0042, 1'b0};
    vecs[7] = '{1,    1'b1, 1'b1, 1'b1, 16'h0000, 1'b0};
    vecs[8] = '{3,    1'b1, 1'b1, 1'b0, 16'h0003, 1'b0};

    // Reset state and first scan step
    repeat (3) step();
    chk("rst_an",    32'(bus.an),    32'(4'b1110));
    chk("rst_seg",   32'(bus.seg),   32'(7'b1000000));
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_dp",    32'(bus.dp),    32'h1);
    chk("rst_wrap",  32'(bus.wrap),  32'h0);
    rst = 1'b1;
    repeat (4) step();
    chk("scan_hold_an", 32'(bus.an), 32'(4'b1110));
    step();
    chk("scan1_an",  32'(bus.an),  32'(4'b1101));
    chk("scan1_seg", 32'(bus.seg), 32'(7'b1111111));

    // Counter vectors: carry chain, gating, clear priority, held tick
    for (int v = 0; v < 9; v++) begin
      bus.tick  = vecs[v].tick;
      bus.en    = vecs[v].en;
      bus.clr   = vecs[v].clr;
      wrap_seen = 1'b0;
      for (int r = 0; r < vecs[v].rep; r++) begin
        step();
        wrap_seen = wrap_seen | bus.wrap;
      end
      chk($sformatf("vec%0d_count", v), 32'(bus.count), 32'(vecs[v].exp_count));
      chk($sformatf("vec%0d_wrap", v),  32'(wrap_seen),  32'(vecs[v].exp_wrap_seen));
    end
    bus.tick = 1'b0;
    bus.clr  = 1'b0;

    // Scan and decode of 1234
    tick_n(1231);
    chk("cnt_1234", 32'(bus.count), 32'h1234);
    step();
    wait_an(4'b1110, "d0_an");
    chk("d0_seg", 32'(bus.seg), 32'(7'b0011001));
    repeat (4) step();
    chk("d1_an",  32'(bus.an),  32'(4'b1101));
    chk("d1_seg", 32'(bus.seg), 32'(7'b0110000));
    repeat (4) step();
    chk("d2_an",  32'(bus.an),  32'(4'b1011));
    chk("d2_seg", 32'(bus.seg), 32'(7'b0100100));
    repeat (4) step();
    chk("d3_an",  32'(bus.an),  32'(4'b0111));
    chk("d3_seg", 32'(bus.seg), 32'(7'b1111001));

    // Rollover 9999 -> 0000
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    tick_n(9999);
    chk("cnt_9999",  32'(bus.count), 32'h9999);
    chk("wrap_pre",  32'(bus.wrap),  32'h0);
    tick_n(1);
    chk("roll_count", 32'(bus.count), 32'h0000);
    chk("roll_wrap",  32'(bus.wrap),  32'h1);
    step();
    chk("roll_wrap_off", 32'(bus.wrap), 32'h0);
    wait_an(4'b1110, "roll_d0_an");
    chk("roll_d0_seg", 32'(bus.seg), 32'(7'b1000000));

    // Leading-zero blanking of 0050
    tick_n(50);
    chk("cnt_0050", 32'(bus.count), 32'h0050);
    step();
    wait_an(4'b1011, "b2_an");
    chk("b2_seg", 32'(bus.seg), 32'(7'b1111111));
    repeat (4) step();
    chk("b3_an",  32'(bus.an),  32'(4'b0111));
    chk("b3_seg", 32'(bus.seg), 32'(7'b1111111));
    repeat (4) step();
    chk("b0_an",  32'(bus.an),  32'(4'b1110));
    chk("b0_seg", 32'(bus.seg), 32'(7'b1000000));
    repeat (4) step();
    chk("b1_an",  32'(bus.an),  32'(4'b1101));
    chk("b1_seg", 32'(bus.seg), 32'(7'b0010010));

    // Asynchronous reset mid-slot
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_an",    32'(bus.an),    32'(4'b1110));
    chk("arst_seg",   32'(bus.seg),   32'(7'b1000000));
    chk("arst_count", 32'(bus.count), 32'h0);
    chk("arst_dp",    32'(bus.dp),    32'h1);
    step();
    rst = 1'b1;
    repeat (4) step();
    chk("post_rst_an", 32'(bus.an), 32'(4'b1110));
    step();
    chk("post_rst_adv_an", 32'(bus.an), 32'(4'b1101));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
